// File: rtl/cva6_obi_port_arbiter.sv
// ---------------------------------------------------------------------------
// cva6_obi_port_arbiter
//
// Shares one OBI manager port between NumReq requesters. Index 0 is fetch,
// 1 is load, 2 is store and 3 is amo.
//
// Arbitration is round-robin. After a grant to requester k, requester k+1
// has the highest priority. An address phase that sees no grant is locked
// (IDLE -> LOCK) to the chosen requester until the grant arrives, so the
// address stays stable on the manager port. Each accepted request pushes its
// requester index into an in-order ID FIFO that is MaxOutstanding deep. The
// FIFO head steers the response channel back to the right requester.
//
// Parameters
//   NumReq         number of requesters
//   MaxOutstanding accepted-but-unanswered transaction limit (power of 2, >= 2)
//   obi_req_t      request struct  (req, reqpar, a, rready, rreadypar)
//   obi_rsp_t      response struct (gnt, gntpar, rvalid, rvalidpar, r)
//   The struct defaults are a minimal OBI-shaped layout. This lets the block
//   elaborate on its own, because it reads named fields.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous, active-high reset
//   req_i      per-requester OBI requests
//   rsp_o      per-requester OBI responses (gnt combinational, zero latency)
//   mgr_req_o  shared manager-port request
//   mgr_rsp_i  shared manager-port response
//   err_o      sticky error: rvalid with no outstanding ID, plus parity
//              errors when checking is enabled
//
// Build option
//   CVA6_OBI_ARB_PARITY_CHECK_EN  when defined, checks gntpar/rvalidpar
//                                 against the inverse of gnt/rvalid on every
//                                 cycle and flags any mismatch on err_o
// ---------------------------------------------------------------------------
module cva6_obi_port_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type obi_req_t = struct packed {
    logic        req;
    logic        reqpar;
    logic [31:0] a;
    logic        rready;
    logic        rreadypar;
  },
  parameter type obi_rsp_t = struct packed {
    logic        gnt;
    logic        gntpar;
    logic        rvalid;
    logic        rvalidpar;
    logic [31:0] r;
  }
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t req_i [NumReq],
  output obi_rsp_t rsp_o [NumReq],
  output obi_req_t mgr_req_o,
  input  obi_rsp_t mgr_rsp_i,
  output logic     err_o
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CandW = IdxW + 1;
  localparam int unsigned PtrW  = $clog2(MaxOutstanding);
  localparam int unsigned CntW  = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t             LastIdx  = idx_t'(NumReq - 1);
  localparam logic [CandW-1:0] NumReqC  = CandW'(NumReq);
  localparam cnt_t             MaxCnt   = cnt_t'(MaxOutstanding);

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  // Priority to use after a grant to index i, wrapping at NumReq.
  function automatic idx_t rr_next(input idx_t i);
    return (i == LastIdx) ? idx_t'(0) : i + idx_t'(1);
  endfunction

  // A parity bit is correct when it is the inverse of its signal.
  function automatic logic par_bad(input logic v, input logic p);
    return (p == v);
  endfunction

  // Control state
  state_e           state_q;
  idx_t             lock_idx_q;
  idx_t             rr_q;
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  cnt_t             cnt_q;
  logic             err_q;

  // ID storage (data only, no reset)
  idx_t             fifo_q [MaxOutstanding];

  // Combinational decode
  logic [CandW-1:0] cand;
  logic             rr_vld;
  idx_t             rr_sel;
  logic             sel_vld;
  idx_t             sel;
  logic             full;
  logic             empty;
  idx_t             head;
  logic             mgr_req_vld;
  logic             accept;
  logic             head_rready;
  logic             rvalid_routed;
  logic             pop;
  logic             orphan_rvalid;
  logic             parity_err;
  logic             unused_par;

  // Round-robin search, starting at rr_q and wrapping at NumReq.
  always_comb begin
    cand   = '0;
    rr_vld = 1'b0;
    rr_sel = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_q} + CandW'(i);
      if (cand >= NumReqC) begin
        cand = cand - NumReqC;
      end
      if (!rr_vld && req_i[cand[IdxW-1:0]].req) begin
        rr_vld = 1'b1;
        rr_sel = cand[IdxW-1:0];
      end
    end
  end

  // A locked address phase overrides the round-robin choice. The locked
  // requester stays selected even if it drops req, so the address cannot
  // change under a pending grant.
  always_comb begin
    if (state_q == LOCK) begin
      sel_vld = 1'b1;
      sel     = lock_idx_q;
    end else begin
      sel_vld = rr_vld;
      sel     = rr_sel;
    end
  end

  assign full  = (cnt_q == MaxCnt);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Full is judged on the registered count. A pop in the same cycle does not
  // unblock a new request until the next cycle.
  assign mgr_req_vld   = sel_vld && !full && !rst_i;
  assign accept        = mgr_req_vld && mgr_rsp_i.gnt;

  assign head_rready   = !empty && req_i[head].rready;
  assign rvalid_routed = !empty && mgr_rsp_i.rvalid;
  assign pop           = rvalid_routed && head_rready;
  assign orphan_rvalid = empty && mgr_rsp_i.rvalid;

`ifdef CVA6_OBI_ARB_PARITY_CHECK_EN
  assign parity_err = par_bad(mgr_rsp_i.gnt, mgr_rsp_i.gntpar) ||
                      par_bad(mgr_rsp_i.rvalid, mgr_rsp_i.rvalidpar);
`else
  assign parity_err = 1'b0;
`endif

  // Parity inputs that this block never consumes.
  always_comb begin
    unused_par = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      unused_par = unused_par ^ req_i[k].reqpar ^ req_i[k].rreadypar;
    end
`ifndef CVA6_OBI_ARB_PARITY_CHECK_EN
    unused_par = unused_par ^ mgr_rsp_i.gntpar ^ mgr_rsp_i.rvalidpar;
`endif
    unused_par = unused_par ^ par_bad(1'b0, 1'b1);
  end

  // Manager-port request
  always_comb begin
    mgr_req_o           = '0;
    mgr_req_o.req       = mgr_req_vld;
    mgr_req_o.reqpar    = !mgr_req_vld;
    mgr_req_o.a         = sel_vld ? req_i[sel].a : '0;
    mgr_req_o.rready    = head_rready;
    mgr_req_o.rreadypar = !head_rready;
  end

  // Requester-side responses: grant to the selected requester, response to
  // the FIFO head
  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      rsp_o[k]           = '0;
      rsp_o[k].gnt       = mgr_req_vld && (sel == idx_t'(k)) && mgr_rsp_i.gnt;
      rsp_o[k].gntpar    = !rsp_o[k].gnt;
      rsp_o[k].rvalid    = rvalid_routed && (head == idx_t'(k));
      rsp_o[k].rvalidpar = !rsp_o[k].rvalid;
      if (!empty && (head == idx_t'(k))) begin
        rsp_o[k].r = mgr_rsp_i.r;
      end
    end
  end

  assign err_o = err_q;

  // Arbitration FSM and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mgr_req_vld && !mgr_rsp_i.gnt) begin
            state_q    <= LOCK;
            lock_idx_q <= sel;
          end
        end
        LOCK: begin
          if (mgr_rsp_i.gnt) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        rr_q <= rr_next(sel);
      end
    end
  end

  // ID FIFO control. Pointers wrap naturally because the depth is a power
  // of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ID FIFO storage
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

  // Sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (orphan_rvalid || parity_err) begin
      err_q <= 1'b1;
    end
  end

endmodule
